dp_jtag_master: RTL and testbench

- Synthesizable JTAG scan sequencer that drives tck/tms/tdi/tdo of the debug transport module (dp_dtm) from the system clock.
- Turns simple requests (optional IR write followed by an optional DR scan of programmable length) into correct TAP state walks and returns the captured tdo bits.
- Sits between a host-side request port (bridge, ROM-driven boot loader or bench) and the DTM's JTAG pins, replacing hand-written tck/tms sequences.

---
 rtl/dp_jtag_master_if.sv | 40 ++++
 rtl/dp_jtag_master.sv | 245 ++++++++++++++++++++++++
 tb/tb_dp_jtag_master.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dp_jtag_master_if.sv
// ----------------------------------------------------------------------------
// dp_jtag_master_if
//   Request/response port of the JTAG scan sequencer.
//
//   Request channel  (master -> slave):
//     req_valid, req_ir_en, req_ir[IR_W], req_len[LEN_W], req_dr[DR_MAX]
//   Request ready    (slave  -> master): req_ready
//   Response channel (slave  -> master): resp_valid, resp_data[DR_MAX]
//   Response ready   (master -> slave):  resp_ready
//
//   The host (bridge, boot ROM sequencer, bench) uses the master modport.
//   dp_jtag_master uses the slave modport.
// ----------------------------------------------------------------------------
interface dp_jtag_master_if #(
  parameter int IR_W   = 5,
  parameter int DR_MAX = 64,
  parameter int LEN_W  = 7
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_ir_en;
  logic [IR_W-1:0]   req_ir;
  logic [LEN_W-1:0]  req_len;
  logic [DR_MAX-1:0] req_dr;
  logic              resp_valid;
  logic              resp_ready;
  logic [DR_MAX-1:0] resp_data;

  modport master (
    output req_valid, req_ir_en, req_ir, req_len, req_dr, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_ir_en, req_ir, req_len, req_dr, resp_ready,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/dp_jtag_master.sv
// ----------------------------------------------------------------------------
// dp_jtag_master
//   JTAG scan sequencer. Converts a request (optional IR write, then an
//   optional DR scan of up to DR_MAX bits) into TAP state walks on
//   tck/tms/tdi, starting and ending in Run-Test/Idle, and returns the tdo
//   bits captured during the DR shift, right-justified.
//
//   Ports
//     clk   in   system clock
//     trst  in   asynchronous active-high reset (also resets the attached TAP)
//     bus   slave modport of dp_jtag_master_if (request/response handshakes)
//     busy  out  high from request accept until response handshake and
//                during the post-reset Test-Logic-Reset walk
//     tck   out  test clock, period 2*TCK_DIV clk cycles while scanning
//     tms   out  test mode select, changes with the falling tck edge
//     tdi   out  test data in, changes with the falling tck edge
//     tdo   in   test data out, sampled with the rising tck edge
// ----------------------------------------------------------------------------
module dp_jtag_master #(
  parameter int IR_W    = 5,
  parameter int DR_MAX  = 64,
  parameter int LEN_W   = 7,
  parameter int TCK_DIV = 2
) (
  input  logic                 clk,
  input  logic                 trst,
  dp_jtag_master_if.slave      bus,
  output logic                 busy,
  output logic                 tck,
  output logic                 tms,
  output logic                 tdi,
  input  logic                 tdo
);

  localparam int               DIV_W    = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);
  localparam logic [LEN_W-1:0] DR_MAX_L = LEN_W'(DR_MAX);
  localparam logic [LEN_W-1:0] IR_LAST  = LEN_W'(IR_W - 1);

  typedef enum logic [3:0] {
    TLR_WALK,
    IDLE,
    IR_ENTER,
    IR_SHIFT,
    IR_EXIT,
    DR_ENTER,
    DR_SHIFT,
    DR_EXIT,
    RESP
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q,   div_d;
  logic               tck_q,   tck_d;
  logic               tms_q,   tms_d;
  logic               tdi_q,   tdi_d;
  logic [LEN_W-1:0]   cnt_q,   cnt_d;
  logic [IR_W-1:0]    ir_q,    ir_d;
  logic [DR_MAX-1:0]  dr_q,    dr_d;
  logic [LEN_W-1:0]   len_q,   len_d;
  logic [DR_MAX-1:0]  cap_q,   cap_d;
  logic               fin_q,   fin_d;

  // Scratch for the "present the next bit" step of the bit engine.
  state_t             s_new;
  logic [LEN_W-1:0]   c_new;
  logic               present;

  // tms value for a bit of a given state. cnt counts the bits remaining in
  // that state minus one, so cnt==0 is the final bit of the state.
  function automatic logic tms_for(input state_t s, input logic [LEN_W-1:0] c);
    logic t;
    case (s)
      TLR_WALK:           t = (c != '0);             // 1,1,1,1,1,0
      IR_ENTER:           t = (c >= LEN_W'(2));      // 1,1,0,0
      DR_ENTER:           t = (c == LEN_W'(2));      // 1,0,0
      IR_SHIFT, DR_SHIFT: t = (c == '0);             // last shift bit exits
      IR_EXIT, DR_EXIT:   t = (c == LEN_W'(1));      // 1,0
      default:            t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    return (l > DR_MAX_L) ? DR_MAX_L : l;
  endfunction

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tck_d   = tck_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    cnt_d   = cnt_q;
    ir_d    = ir_q;
    dr_d    = dr_q;
    len_d   = len_q;
    cap_d   = cap_q;
    fin_d   = fin_q;
    s_new   = state_q;
    c_new   = cnt_q;
    present = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          ir_d  = bus.req_ir;
          dr_d  = bus.req_dr;
          len_d = clamp_len(bus.req_len);
          cap_d = '0;
          div_d = '0;
          // Both scan types begin with tms=1 (RTI -> Select-DR), presented
          // on the accept edge so bit 0 gets a full low phase.
          if (bus.req_ir_en) begin
            state_d = IR_ENTER;
            cnt_d   = LEN_W'(3);
            tms_d   = 1'b1;
          end else if (bus.req_len != '0) begin
            state_d = DR_ENTER;
            cnt_d   = LEN_W'(2);
            tms_d   = 1'b1;
          end else begin
            state_d = RESP;
          end
        end
      end

      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        if (fin_q) begin
          // One idle clk after the final tck fall before handing control back.
          fin_d   = 1'b0;
          state_d = (state_q == TLR_WALK) ? IDLE : RESP;
        end else if (div_q != DIV_LAST) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          tck_d = ~tck_q;
          if (!tck_q) begin
            // Rising tck: sample tdo. Captured bits enter at the MSB and are
            // right-justified once the shift completes.
            if (state_q == DR_SHIFT) begin
              cap_d = {tdo, cap_q[DR_MAX-1:1]};
            end
          end else if (cnt_q != '0) begin
            present = 1'b1;
            c_new   = cnt_q - 1'b1;
          end else begin
            case (state_q)
              IR_ENTER: begin
                present = 1'b1;
                s_new   = IR_SHIFT;
                c_new   = IR_LAST;
              end
              IR_SHIFT: begin
                present = 1'b1;
                s_new   = IR_EXIT;
                c_new   = LEN_W'(1);
              end
              IR_EXIT: begin
                if (len_q != '0) begin
                  present = 1'b1;
                  s_new   = DR_ENTER;
                  c_new   = LEN_W'(2);
                end else begin
                  fin_d = 1'b1;
                end
              end
              DR_ENTER: begin
                present = 1'b1;
                s_new   = DR_SHIFT;
                c_new   = len_q - 1'b1;
              end
              DR_SHIFT: begin
                present = 1'b1;
                s_new   = DR_EXIT;
                c_new   = LEN_W'(1);
                cap_d   = cap_q >> (DR_MAX - int'(len_q));
              end
              default: begin
                fin_d = 1'b1;
              end
            endcase
          end
        end
      end
    endcase

    // Falling tck edge that starts another bit: drive its tms/tdi now.
    if (present) begin
      state_d = s_new;
      cnt_d   = c_new;
      tms_d   = tms_for(s_new, c_new);
      if (s_new == IR_SHIFT) begin
        tdi_d = ir_q[0];
        ir_d  = ir_q >> 1;
      end else if (s_new == DR_SHIFT) begin
        tdi_d = dr_q[0];
        dr_d  = dr_q >> 1;
      end
    end
  end

  always_ff @(posedge clk or posedge trst) begin
    if (trst) begin
      state_q <= TLR_WALK;
      div_q   <= '0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      cnt_q   <= LEN_W'(5);
      ir_q    <= '0;
      dr_q    <= '0;
      len_q   <= '0;
      cap_q   <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tck_q   <= tck_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
      dr_q    <= dr_d;
      len_q   <= len_d;
      cap_q   <= cap_d;
      fin_q   <= fin_d;
    end
  end

  assign tck            = tck_q;
  assign tms            = tms_q;
  assign tdi            = tdi_q;
  assign busy           = (state_q != IDLE);
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_data  = cap_q;

endmodule

// File: tb/tb_dp_jtag_master.sv
module tb_dp_jtag_master;

  localparam int IR_W    = 5;
  localparam int DR_MAX  = 64;
  localparam int LEN_W   = 7;
  localparam int TCK_DIV = 2;

  logic clk  = 1'b0;
  logic trst = 1'b1;
  logic busy, tck, tms, tdi, tdo;

  dp_jtag_master_if #(.IR_W(IR_W), .DR_MAX(DR_MAX), .LEN_W(LEN_W)) bus_if ();

  dp_jtag_master #(.IR_W(IR_W), .DR_MAX(DR_MAX), .LEN_W(LEN_W), .TCK_DIV(TCK_DIV)) dut (
    .clk  (clk),
    .trst (trst),
    .bus  (bus_if.slave),
    .busy (busy),
    .tck  (tck),
    .tms  (tms),
    .tdi  (tdi),
    .tdo  (tdo)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // tck edge monitor
  int   n_edges = 0;
  logic tms_log [4096];
  logic tdi_log [4096];

  always @(posedge tck) begin
    tms_log[12'(n_edges)] <= tms;
    tdi_log[12'(n_edges)] <= tdi;
    n_edges <= n_edges + 1;
  end

  function automatic logic [127:0] gather_tms(input int start, input int cnt);
    logic [127:0] v = '0;
    for (int i = 0; i < cnt && i < 128; i++) v[7'(i)] = tms_log[12'(start + i)];
    return v;
  endfunction

  function automatic logic [127:0] gather_tdi(input int start, input int cnt);
    logic [127:0] v = '0;
    for (int i = 0; i < cnt && i < 128; i++) v[7'(i)] = tdi_log[12'(start + i)];
    return v;
  endfunction

  // TAP model: IDCODE device, or 1-bit tdi->tdo loopback in Shift-DR
  typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                            SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_t;
  tap_t        tap_st;
  logic [4:0]  tap_ir, ir_sr;
  logic [31:0] dr_sr;
  logic        lb;
  bit          loopback = 1'b0;

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      TLR:   return m ? TLR   : RTI;
      RTI:   return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR: return m ? EX1DR : SHDR;
      SHDR:  return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDR  : PADR;
      PADR:  return m ? EX2DR : PADR;
      EX2DR: return m ? UPDR  : SHDR;
      UPDR:  return m ? SELDR : RTI;
      SELIR: return m ? TLR   : CAPIR;
      CAPIR: return m ? EX1IR : SHIR;
      SHIR:  return m ? EX1IR : SHIR;
      EX1IR: return m ? UPIR  : PAIR;
      PAIR:  return m ? EX2IR : PAIR;
      EX2IR: return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge tck or posedge trst) begin
    if (trst) begin
      tap_st <= TLR;
      tap_ir <= 5'h01;
      ir_sr  <= '0;
      dr_sr  <= '0;
      lb     <= 1'b0;
    end else begin
      case (tap_st)
        TLR:   tap_ir <= 5'h01;
        CAPIR: ir_sr  <= 5'b00001;
        SHIR:  ir_sr  <= {tdi, ir_sr[4:1]};
        UPIR:  tap_ir <= ir_sr;
        CAPDR: begin
          dr_sr <= (tap_ir == 5'h01) ? 32'h1234_5678 : 32'h0;
          lb    <= 1'b0;
        end
        SHDR: begin
          dr_sr <= {tdi, dr_sr[31:1]};
          lb    <= tdi;
        end
        default: ;
      endcase
      tap_st <= tap_next(tap_st, tms);
    end
  end

  assign tdo = loopback ? lb :
               (tap_st == SHDR) ? dr_sr[0] :
               (tap_st == SHIR) ? ir_sr[0] : 1'b0;

  // Scoreboard of expected scans
  typedef struct {
    logic [127:0] tms;
    logic [127:0] tdi;
    logic [127:0] msk;
    logic [63:0]  data;
    int           n;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t build(input bit ir_en, input logic [4:0] ir, input int len,
                                 input logic [63:0] dr, input logic [63:0] data);
    exp_t e;
    int k = 0;
    int l = (len > DR_MAX) ? DR_MAX : len;
    e.tms = '0; e.tdi = '0; e.msk = '0; e.data = data;
    if (ir_en) begin
      e.tms[7'(k)] = 1'b1; e.tms[7'(k + 1)] = 1'b1; k += 4;
      for (int i = 0; i < IR_W; i++) begin
        e.tms[7'(k)] = (i == IR_W - 1); e.tdi[7'(k)] = ir[3'(i)]; e.msk[7'(k)] = 1'b1; k++;
      end
      e.tms[7'(k)] = 1'b1; k += 2;
    end
    if (l > 0) begin
      e.tms[7'(k)] = 1'b1; k += 3;
      for (int i = 0; i < l; i++) begin
        e.tms[7'(k)] = (i == l - 1); e.tdi[7'(k)] = dr[6'(i)]; e.msk[7'(k)] = 1'b1; k++;
      end
      e.tms[7'(k)] = 1'b1; k += 2;
    end
    e.n = k;
    return e;
  endfunction

  function automatic logic [63:0] lb_expect(input logic [63:0] dr, input int len);
    int l = (len > DR_MAX) ? DR_MAX : len;
    logic [63:0] m = (l >= 64) ? '1 : ((64'd1 << l) - 64'd1);
    return (dr << 1) & m;
  endfunction

  task automatic do_req(input bit ir_en, input logic [4:0] ir, input int len,
                        input logic [63:0] dr, input logic [63:0] data, input int hold);
    exp_t e;
    int start, t, h_edges;
    logic [63:0] held;
    sb.push_back(build(ir_en, ir, len, dr, data));
    t = 0;
    @(negedge clk);
    while (!bus_if.req_ready && t < 200) begin @(negedge clk); t++; end
    check("req_ready_idle", bus_if.req_ready, 1);
    start = n_edges;
    bus_if.req_valid = 1'b1;
    bus_if.req_ir_en = ir_en;
    bus_if.req_ir    = ir;
    bus_if.req_len   = 7'(len);
    bus_if.req_dr    = dr;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    check("req_ready_after_accept", bus_if.req_ready, 0);
    check("busy_after_accept", busy, 1);
    t = 0;
    while (!bus_if.resp_valid && t < 2000) begin @(negedge clk); t++; end
    check("resp_valid", bus_if.resp_valid, 1);
    if (hold > 0) begin
      held    = bus_if.resp_data;
      h_edges = n_edges;
      repeat (hold) begin
        @(negedge clk);
        check("bp_resp_valid", bus_if.resp_valid, 1);
        check("bp_data_stable", bus_if.resp_data, held);
        check("bp_req_ready", bus_if.req_ready, 0);
      end
      check("bp_no_tck", n_edges, h_edges);
    end
    e = sb.pop_front();
    check("resp_data", bus_if.resp_data, e.data);
    check("tck_edges", n_edges - start, e.n);
    check("tms_seq", gather_tms(start, e.n), e.tms);
    check("tdi_seq", gather_tdi(start, e.n) & e.msk, e.tdi & e.msk);
    check("tap_in_rti", tap_st, RTI);
    check("tck_low_at_end", tck, 0);
    bus_if.resp_ready = 1'b1;
    @(negedge clk);
    bus_if.resp_ready = 1'b0;
    check("resp_valid_drop", bus_if.resp_valid, 0);
    check("req_ready_return", bus_if.req_ready, 1);
    check("busy_clear", busy, 0);
  endtask

  task automatic check_tlr_walk(input string tag);
    int start = n_edges;
    int t = 0;
    int rv_seen = 0;
    logic prev_tck = 1'b0;
    trst = 1'b0;
    while (!bus_if.req_ready && t < 200) begin
      prev_tck = tck;
      if (bus_if.resp_valid) rv_seen++;
      @(negedge clk);
      t++;
    end
    check({tag, "_ready"}, bus_if.req_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_edges"}, n_edges - start, 6);
    check({tag, "_tms"}, gather_tms(start, 6), 128'h1F);
    check({tag, "_tck_low_before_ready"}, prev_tck, 0);
    check({tag, "_tap_rti"}, tap_st, RTI);
    check({tag, "_no_resp"}, rv_seen, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] dr;
    int start, t, lv;
    bit ie;
    bus_if.req_valid  = 1'b0;
    bus_if.req_ir_en  = 1'b0;
    bus_if.req_ir     = '0;
    bus_if.req_len    = '0;
    bus_if.req_dr     = '0;
    bus_if.resp_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_tck", tck, 0);
    check("rst_tms", tms, 1);
    check("rst_tdi", tdi, 0);
    check("rst_req_ready", bus_if.req_ready, 0);
    check("rst_resp_valid", bus_if.resp_valid, 0);
    check("rst_resp_data", bus_if.resp_data, 0);
    check("rst_busy", busy, 1);

    check_tlr_walk("tlr");

    do_req(1'b1, 5'h01, 0, 64'h0, 64'h0, 0);                  // IR only
    do_req(1'b1, 5'h01, 32, 64'h0, 64'h1234_5678, 10);        // IDCODE read + backpressure
    do_req(1'b0, 5'h00, 0, 64'h0, 64'h0, 0);                  // empty request

    loopback = 1'b1;
    dr = 64'h0AB_E123_4567;
    do_req(1'b0, 5'h00, 41, dr, lb_expect(dr, 41), 0);        // DMI loopback
    dr = {$urandom, $urandom};
    do_req(1'b0, 5'h00, 100, dr, lb_expect(dr, 100), 0);      // clamp to 64
    for (int r = 0; r < 4; r++) begin
      case (r)
        0:       lv = 1;
        1:       lv = 63;
        2:       lv = 64;
        default: lv = $urandom_range(2, 62);
      endcase
      ie = 1'($urandom_range(0, 1));
      dr = {$urandom, $urandom};
      do_req(ie, 5'($urandom), lv, dr, lb_expect(dr, lv), 0);
    end

    // Reset in the middle of DR shift bit 20
    dr = 64'h0AB_E123_4567;
    @(negedge clk);
    start = n_edges;
    bus_if.req_valid = 1'b1;
    bus_if.req_ir_en = 1'b0;
    bus_if.req_len   = 7'd41;
    bus_if.req_dr    = dr;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    t = 0;
    while (n_edges < start + 24 && t < 1000) begin @(negedge clk); t++; end
    check("midscan_reached", (n_edges - start) >= 24, 1);
    #1 trst = 1'b1;
    #1;
    check("mid_rst_tck", tck, 0);
    check("mid_rst_tms", tms, 1);
    check("mid_rst_tdi", tdi, 0);
    check("mid_rst_req_ready", bus_if.req_ready, 0);
    check("mid_rst_resp_valid", bus_if.resp_valid, 0);
    check("mid_rst_resp_data", bus_if.resp_data, 0);
    check("mid_rst_busy", busy, 1);
    repeat (3) @(negedge clk);
    check_tlr_walk("tlr_after_abort");
    t = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus_if.resp_valid) t++;
    end
    check("no_resp_for_dropped", t, 0);

    loopback = 1'b0;
    do_req(1'b0, 5'h00, 32, 64'h0, 64'h1234_5678, 0);         // recovery read

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
